// File: rtl/fc_classifier.sv
// rtl/fc_classifier.sv - fully connected classifier: per-class MAC, bias with saturation, argmax
module fc_classifier #(
    parameter int CLASS_NUM  = 2,
    parameter int INPUT_SIZE = 30,
    parameter int D_WL       = 24,
    parameter int FL         = 14
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          clr,
    input  logic                          in_valid,
    output logic                          in_ready,
    input  logic signed [D_WL-1:0]        x,
    output logic [((INPUT_SIZE > 1) ? $clog2(INPUT_SIZE) : 1)-1:0] w_addr,
    input  logic [CLASS_NUM*D_WL-1:0]     w_i,
    input  logic [CLASS_NUM*D_WL-1:0]     b_i,
    output logic                          o_valid,
    input  logic                          o_ready,
    output logic [CLASS_NUM*D_WL-1:0]     f_o,
    output logic [((CLASS_NUM > 1) ? $clog2(CLASS_NUM) : 1)-1:0] cls_o,
    output logic signed [D_WL-1:0]        max_o
);
    localparam int CLS_W = (CLASS_NUM > 1) ? $clog2(CLASS_NUM) : 1;
    localparam int IDX_W = (INPUT_SIZE > 1) ? $clog2(INPUT_SIZE) : 1;
    localparam int ACC_W = 2 * D_WL + IDX_W + 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(INPUT_SIZE - 1);
    localparam logic [CLS_W-1:0] LAST_CLS = CLS_W'(CLASS_NUM - 1);
    localparam logic signed [ACC_W:0] SUM_MAX = (ACC_W+1)'((64'sd1 <<< (D_WL - 1)) - 64'sd1);
    localparam logic signed [ACC_W:0] SUM_MIN = ~SUM_MAX;
    localparam logic signed [D_WL-1:0] OUT_MAX = {1'b0, {(D_WL-1){1'b1}}};
    localparam logic signed [D_WL-1:0] OUT_MIN = {1'b1, {(D_WL-1){1'b0}}};

    typedef enum logic [1:0] {ACC, BIAS, ARG, OUT} state_t;

    state_t                   state;
    logic [IDX_W-1:0]         idx;
    logic [CLS_W-1:0]         arg_idx;
    logic [CLS_W-1:0]         best_idx;
    logic signed [D_WL-1:0]   best_val;
    logic signed [ACC_W-1:0]  acc    [CLASS_NUM];
    logic signed [D_WL-1:0]   score  [CLASS_NUM];
    logic signed [2*D_WL-1:0] prod   [CLASS_NUM];
    logic signed [ACC_W:0]    sum    [CLASS_NUM];
    logic signed [D_WL-1:0]   biased [CLASS_NUM];
    logic signed [D_WL-1:0]   cand;
    logic                     take;
    logic signed [D_WL-1:0]   next_val;
    logic [CLS_W-1:0]         next_idx;

    assign in_ready = (state == ACC);
    assign w_addr   = (state == ACC) ? idx : '0;

    always_comb begin
        for (int j = 0; j < CLASS_NUM; j++) begin
            prod[j] = x * $signed(w_i[j*D_WL +: D_WL]);
            // arithmetic shift floors toward minus infinity; no rounding term
            sum[j]  = (ACC_W+1)'(acc[j] >>> FL) + (ACC_W+1)'($signed(b_i[j*D_WL +: D_WL]));
            if (sum[j] > SUM_MAX)
                biased[j] = OUT_MAX;
            else if (sum[j] < SUM_MIN)
                biased[j] = OUT_MIN;
            else
                biased[j] = sum[j][D_WL-1:0];
        end
        cand     = score[arg_idx];
        take     = (arg_idx == '0) || (cand > best_val);
        next_val = take ? cand : best_val;
        next_idx = take ? arg_idx : best_idx;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= ACC;
            idx      <= '0;
            arg_idx  <= '0;
            best_idx <= '0;
            best_val <= '0;
            o_valid  <= 1'b0;
            f_o      <= '0;
            cls_o    <= '0;
            max_o    <= '0;
            for (int j = 0; j < CLASS_NUM; j++) begin
                acc[j]   <= '0;
                score[j] <= '0;
            end
        end else if (clr) begin
            state   <= ACC;
            idx     <= '0;
            arg_idx <= '0;
            o_valid <= 1'b0;
            for (int j = 0; j < CLASS_NUM; j++)
                acc[j] <= '0;
        end else begin
            case (state)
                ACC: begin
                    if (in_valid) begin
                        for (int j = 0; j < CLASS_NUM; j++)
                            acc[j] <= acc[j] + ACC_W'(prod[j]);
                        if (idx == LAST_IDX) begin
                            idx   <= '0;
                            state <= BIAS;
                        end else begin
                            idx <= idx + 1'b1;
                        end
                    end
                end
                BIAS: begin
                    for (int j = 0; j < CLASS_NUM; j++) begin
                        score[j] <= biased[j];
                        acc[j]   <= '0;
                    end
                    arg_idx <= '0;
                    state   <= ARG;
                end
                ARG: begin
                    best_val <= next_val;
                    best_idx <= next_idx;
                    if (arg_idx == LAST_CLS) begin
                        // results are published together so they only change on entry to OUT
                        for (int j = 0; j < CLASS_NUM; j++)
                            f_o[j*D_WL +: D_WL] <= score[j];
                        max_o   <= next_val;
                        cls_o   <= next_idx;
                        o_valid <= 1'b1;
                        arg_idx <= '0;
                        state   <= OUT;
                    end else begin
                        arg_idx <= arg_idx + 1'b1;
                    end
                end
                OUT: begin
                    if (o_ready) begin
                        o_valid <= 1'b0;
                        state   <= ACC;
                    end
                end
                default: state <= ACC;
            endcase
        end
    end
endmodule

// File: tb/tb_fc_classifier.sv
// tb/tb_fc_classifier.sv - scoreboard bench for fc_classifier
module tb_fc_classifier;
    localparam int CN  = 2;
    localparam int IS  = 4;
    localparam int DW  = 24;
    localparam int FLB = 14;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic              clr = 1'b0;
    logic              in_valid = 1'b0;
    logic              in_ready;
    logic signed [DW-1:0] x = '0;
    logic [1:0]        w_addr;
    logic [CN*DW-1:0]  w_i;
    logic [CN*DW-1:0]  b_i;
    logic              o_valid;
    logic              o_ready = 1'b0;
    logic [CN*DW-1:0]  f_o;
    logic [0:0]        cls_o;
    logic signed [DW-1:0] max_o;

    fc_classifier #(.CLASS_NUM(CN), .INPUT_SIZE(IS), .D_WL(DW), .FL(FLB)) dut (
        .clk(clk), .rst(rst), .clr(clr), .in_valid(in_valid), .in_ready(in_ready),
        .x(x), .w_addr(w_addr), .w_i(w_i), .b_i(b_i), .o_valid(o_valid),
        .o_ready(o_ready), .f_o(f_o), .cls_o(cls_o), .max_o(max_o)
    );

    always #5 clk = ~clk;

    int wm [IS][CN];
    int bv [CN];
    int xs [IS];

    always_comb begin
        w_i = '0;
        b_i = '0;
        for (int j = 0; j < CN; j++) begin
            w_i[j*DW +: DW] = DW'(wm[w_addr][j]);
            b_i[j*DW +: DW] = DW'(bv[j]);
        end
    end

    typedef struct {
        logic [CN*DW-1:0] f;
        logic [0:0]       cls;
        logic [DW-1:0]    mx;
    } res_t;

    res_t sb[$];
    res_t e;
    int n_checks = 0;
    int n_fail   = 0;

    function automatic int sat(input longint v);
        if (v > 64'sd8388607) return 8388607;
        if (v < -64'sd8388608) return -8388608;
        return int'(v);
    endfunction

    task automatic push_model();
        int f[CN];
        res_t r;
        for (int j = 0; j < CN; j++) begin
            longint a = 0;
            for (int k = 0; k < IS; k++)
                a += longint'(xs[k]) * longint'(wm[k][j]);
            f[j] = sat((a >>> FLB) + longint'(bv[j]));
        end
        r.f   = {DW'(f[1]), DW'(f[0])};
        r.cls = (f[1] > f[0]) ? 1'b1 : 1'b0;
        r.mx  = (f[1] > f[0]) ? DW'(f[1]) : DW'(f[0]);
        sb.push_back(r);
    endtask

    task automatic set_frame(input int xv, input int w0, input int w1, input int b0, input int b1);
        for (int k = 0; k < IS; k++) begin
            xs[k]    = xv;
            wm[k][0] = w0;
            wm[k][1] = w1;
        end
        bv[0] = b0;
        bv[1] = b1;
    endtask

    task automatic drive_beats(input int n, input int gap_pct);
        for (int k = 0; k < n; k++) begin
            while (int'($urandom_range(99)) < gap_pct) begin
                in_valid = 1'b0;
                x = DW'($urandom);
                @(posedge clk); #1;
                n_checks++;
                if (w_addr !== 2'(k) || in_ready !== 1'b1) begin
                    n_fail++;
                    $display("FAIL bubble_hold: w_addr=%0d in_ready=%b expected w_addr=%0d in_ready=1", w_addr, in_ready, k);
                end
            end
            in_valid = 1'b1;
            x = DW'(xs[k]);
            @(posedge clk); #1;
        end
        in_valid = 1'b0;
    endtask

    task automatic drive_frame(input int gap_pct);
        drive_beats(IS, gap_pct);
        push_model();
    endtask

    task automatic wait_out(output bit ok, output int lat);
        ok  = 1'b0;
        lat = 0;
        for (int i = 1; i <= 50; i++) begin
            if (!ok) begin
                @(posedge clk); #1;
                if (o_valid) begin
                    ok  = 1'b1;
                    lat = i;
                end
            end
        end
        n_checks++;
        if (!ok) begin
            n_fail++;
            $display("FAIL o_valid_timeout: o_valid=%b expected 1 within 50 cycles", o_valid);
        end
        e = (sb.size() > 0) ? sb.pop_front() : '{default: '0};
    endtask

    task automatic accept();
        o_ready = 1'b1;
        @(posedge clk); #1;
        o_ready = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        @(posedge clk); #1;
        @(posedge clk); #1;
        n_checks++;
        if ({o_valid, w_addr, f_o, cls_o, max_o} !== '0) begin
            n_fail++;
            $display("FAIL reset_outputs: o_valid=%b w_addr=%0d f_o=%h cls=%0d max=%h expected all 0", o_valid, w_addr, f_o, cls_o, max_o);
        end
        rst = 1'b0;
        n_checks++;
        if (in_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL reset_in_ready: got %b expected 1", in_ready);
        end
    endtask

    task automatic test_basic();
        bit ok;
        int lat;
        set_frame(16384, 16384, 8192, 0, 0);
        drive_frame(0);
        wait_out(ok, lat);
        n_checks++;
        if (lat != CN + 1) begin
            n_fail++;
            $display("FAIL basic_latency: got %0d edges expected %0d", lat, CN + 1);
        end
        n_checks++;
        if ({f_o, cls_o, max_o} !== {e.f, e.cls, e.mx}) begin
            n_fail++;
            $display("FAIL basic_result: got f_o=%h cls=%0d max=%h expected f_o=%h cls=%0d max=%h", f_o, cls_o, max_o, e.f, e.cls, e.mx);
        end
        n_checks++;
        if (f_o !== {24'd32768, 24'd65536} || max_o !== 24'sd65536) begin
            n_fail++;
            $display("FAIL basic_const: got f_o=%h max=%h expected f_o=%h max=%h", f_o, max_o, {24'd32768, 24'd65536}, 24'd65536);
        end
        accept();
        n_checks++;
        if (o_valid !== 1'b0 || in_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL basic_release: o_valid=%b in_ready=%b expected 0/1", o_valid, in_ready);
        end
    endtask

    task automatic test_bias_tie();
        bit ok;
        int lat;
        set_frame(16384, 16384, 16384, -16384, 0);
        drive_frame(0);
        wait_out(ok, lat);
        n_checks++;
        if ({f_o, cls_o, max_o} !== {e.f, e.cls, e.mx} || cls_o !== 1'b1) begin
            n_fail++;
            $display("FAIL bias_result: got f_o=%h cls=%0d max=%h expected f_o=%h cls=1 max=%h", f_o, cls_o, max_o, e.f, e.mx);
        end
        accept();
        set_frame(16384, 16384, 16384, 0, 0);
        drive_frame(0);
        wait_out(ok, lat);
        n_checks++;
        if ({f_o, cls_o, max_o} !== {e.f, e.cls, e.mx} || cls_o !== 1'b0) begin
            n_fail++;
            $display("FAIL tie_result: got f_o=%h cls=%0d max=%h expected f_o=%h cls=0 max=%h", f_o, cls_o, max_o, e.f, e.mx);
        end
        accept();
    endtask

    task automatic test_saturation();
        bit ok;
        int lat;
        set_frame(8388607, 8388607, 8388607, 8388607, 8388607);
        drive_frame(0);
        wait_out(ok, lat);
        n_checks++;
        if ({f_o, cls_o, max_o} !== {e.f, e.cls, e.mx} || f_o !== {2{24'h7fffff}}) begin
            n_fail++;
            $display("FAIL sat_pos: got f_o=%h cls=%0d max=%h expected f_o=%h cls=%0d max=%h", f_o, cls_o, max_o, e.f, e.cls, e.mx);
        end
        accept();
        set_frame(-8388608, 8388607, 8388607, 8388607, 8388607);
        drive_frame(0);
        wait_out(ok, lat);
        n_checks++;
        if ({f_o, cls_o, max_o} !== {e.f, e.cls, e.mx} || f_o !== {2{24'h800000}}) begin
            n_fail++;
            $display("FAIL sat_neg: got f_o=%h cls=%0d max=%h expected f_o=%h cls=%0d max=%h", f_o, cls_o, max_o, e.f, e.cls, e.mx);
        end
        accept();
    endtask

    task automatic test_backpressure();
        bit ok;
        int lat;
        logic [CN*DW+DW:0] snap;
        set_frame(16384, 16384, 8192, 0, 0);
        drive_frame(0);
        wait_out(ok, lat);
        n_checks++;
        if ({f_o, cls_o, max_o} !== {e.f, e.cls, e.mx}) begin
            n_fail++;
            $display("FAIL bp_result: got f_o=%h cls=%0d max=%h expected f_o=%h cls=%0d max=%h", f_o, cls_o, max_o, e.f, e.cls, e.mx);
        end
        snap = {f_o, cls_o, max_o};
        for (int i = 0; i < 10; i++) begin
            in_valid = 1'($urandom);
            x = DW'($urandom);
            @(posedge clk); #1;
            n_checks++;
            if ({f_o, cls_o, max_o} !== snap || in_ready !== 1'b0 || o_valid !== 1'b1 || w_addr !== 2'd0) begin
                n_fail++;
                $display("FAIL bp_hold: out=%h in_ready=%b o_valid=%b w_addr=%0d expected out=%h in_ready=0 o_valid=1 w_addr=0", {f_o, cls_o, max_o}, in_ready, o_valid, w_addr, snap);
            end
        end
        in_valid = 1'b0;
        accept();
        n_checks++;
        if (in_ready !== 1'b1 || o_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL bp_release: in_ready=%b o_valid=%b expected 1/0", in_ready, o_valid);
        end
        drive_frame(0);
        wait_out(ok, lat);
        n_checks++;
        if ({f_o, cls_o, max_o} !== {e.f, e.cls, e.mx}) begin
            n_fail++;
            $display("FAIL bp_next_frame: got f_o=%h cls=%0d max=%h expected f_o=%h cls=%0d max=%h", f_o, cls_o, max_o, e.f, e.cls, e.mx);
        end
        accept();
    endtask

    task automatic test_abort();
        bit ok;
        int lat;
        logic [CN*DW+DW:0] snap;
        snap = {f_o, cls_o, max_o};
        set_frame(1000000, 7000000, -5000000, 0, 0);
        drive_beats(2, 0);
        in_valid = 1'b1;
        x = DW'(xs[2]);
        clr = 1'b1;
        @(posedge clk); #1;
        clr = 1'b0;
        in_valid = 1'b0;
        n_checks++;
        if (w_addr !== 2'd0 || in_ready !== 1'b1 || {f_o, cls_o, max_o} !== snap) begin
            n_fail++;
            $display("FAIL abort_state: w_addr=%0d in_ready=%b out=%h expected w_addr=0 in_ready=1 out=%h", w_addr, in_ready, {f_o, cls_o, max_o}, snap);
        end
        set_frame(16384, 16384, 8192, 0, 0);
        drive_frame(0);
        wait_out(ok, lat);
        n_checks++;
        if ({f_o, cls_o, max_o} !== {e.f, e.cls, e.mx} || lat != CN + 1) begin
            n_fail++;
            $display("FAIL abort_result: got f_o=%h cls=%0d max=%h lat=%0d expected f_o=%h cls=%0d max=%h lat=%0d", f_o, cls_o, max_o, lat, e.f, e.cls, e.mx, CN + 1);
        end
        snap = {f_o, cls_o, max_o};
        clr = 1'b1;
        @(posedge clk); #1;
        clr = 1'b0;
        n_checks++;
        if (o_valid !== 1'b0 || in_ready !== 1'b1 || {f_o, cls_o, max_o} !== snap) begin
            n_fail++;
            $display("FAIL abort_in_out: o_valid=%b in_ready=%b out=%h expected 0/1 out=%h", o_valid, in_ready, {f_o, cls_o, max_o}, snap);
        end
    endtask

    task automatic test_gapped();
        bit ok;
        int lat;
        res_t first;
        for (int it = 0; it < 3; it++) begin
            for (int k = 0; k < IS; k++) begin
                xs[k] = int'($urandom_range(65535)) - 32768;
                for (int j = 0; j < CN; j++)
                    wm[k][j] = int'($urandom_range(65535)) - 32768;
            end
            for (int j = 0; j < CN; j++)
                bv[j] = int'($urandom_range(524287)) - 262144;
            drive_frame(0);
            wait_out(ok, lat);
            first = e;
            n_checks++;
            if ({f_o, cls_o, max_o} !== {e.f, e.cls, e.mx}) begin
                n_fail++;
                $display("FAIL gapfree_result: got f_o=%h cls=%0d max=%h expected f_o=%h cls=%0d max=%h", f_o, cls_o, max_o, e.f, e.cls, e.mx);
            end
            accept();
            drive_frame(40);
            wait_out(ok, lat);
            n_checks++;
            if ({f_o, cls_o, max_o} !== {first.f, first.cls, first.mx}) begin
                n_fail++;
                $display("FAIL gapped_result: got f_o=%h cls=%0d max=%h expected f_o=%h cls=%0d max=%h", f_o, cls_o, max_o, first.f, first.cls, first.mx);
            end
            accept();
        end
    endtask

    task automatic test_reset_mid();
        bit ok;
        int lat;
        set_frame(16384, 16384, 8192, 0, 0);
        drive_beats(2, 0);
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        n_checks++;
        if ({o_valid, w_addr, f_o, cls_o, max_o} !== '0 || in_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL reset_mid: o_valid=%b w_addr=%0d f_o=%h cls=%0d max=%h in_ready=%b expected zeros and in_ready=1", o_valid, w_addr, f_o, cls_o, max_o, in_ready);
        end
        drive_frame(0);
        wait_out(ok, lat);
        n_checks++;
        if ({f_o, cls_o, max_o} !== {e.f, e.cls, e.mx}) begin
            n_fail++;
            $display("FAIL reset_mid_result: got f_o=%h cls=%0d max=%h expected f_o=%h cls=%0d max=%h", f_o, cls_o, max_o, e.f, e.cls, e.mx);
        end
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        n_checks++;
        if (o_valid !== 1'b0 || f_o !== '0 || in_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL reset_in_out: o_valid=%b f_o=%h in_ready=%b expected 0/0/1", o_valid, f_o, in_ready);
        end
    endtask

    initial begin
        set_frame(0, 0, 0, 0, 0);
        test_reset();
        test_basic();
        test_bias_tie();
        test_saturation();
        test_backpressure();
        test_abort();
        test_gapped();
        test_reset_mid();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
